// File: rtl/calc2_port_responder.sv
// calc2 single-port responder: two-cycle request capture, ADD/SUB/SHL/SHR compute, in-order result
// queue with per-entry latency countdown. Define CALC_TAG_CHECK_EN to error out duplicate pending tags.
module calc2_port_responder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADD_LAT   = 2,
  parameter int unsigned SHIFT_LAT = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        busy,
  output logic        drop_err
);

  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned MaxLat = (ADD_LAT > SHIFT_LAT) ? ADD_LAT : SHIFT_LAT;
  localparam int unsigned CW     = $clog2(MaxLat + 1);

  localparam logic [PW:0]   Full     = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   FullM1   = (PW + 1)'(DEPTH - 1);
  // Countdown is preloaded with LAT-1 so the pop edge lands the response at LAT+2.
  localparam logic [CW-1:0] AddCnt   = CW'(ADD_LAT - 1);
  localparam logic [CW-1:0] ShiftCnt = CW'(SHIFT_LAT - 1);

  typedef enum logic [0:0] {StIdle, StOp2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [1:0]          tag_q, tag_d;
  logic [31:0]         op1_q, op1_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         occ_q, occ_d;
  logic [DEPTH-1:0]    q_vld_q, q_vld_d;
  logic [1:0]          q_resp_q [DEPTH];
  logic [1:0]          q_resp_d [DEPTH];
  logic [31:0]         q_data_q [DEPTH];
  logic [31:0]         q_data_d [DEPTH];
  logic [1:0]          q_tag_q  [DEPTH];
  logic [1:0]          q_tag_d  [DEPTH];
  logic [CW-1:0]       q_cnt_q  [DEPTH];
  logic [CW-1:0]       q_cnt_d  [DEPTH];
  logic [1:0]          out_resp_q, out_resp_d;
  logic [31:0]         out_data_q, out_data_d;
  logic [1:0]          out_tag_q, out_tag_d;
  logic                drop_q, drop_d;
`ifdef CALC_TAG_CHECK_EN
  logic                dup_q, dup_d;
`endif

  logic                pop, push;
  logic [32:0]         sum;
  logic [1:0]          new_resp;
  logic [31:0]         new_data;
  logic [CW-1:0]       new_cnt;

  assign busy = (occ_q == Full) || ((occ_q == FullM1) && (state_q == StOp2));

  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, req_data_in};
    new_resp = 2'd2;
    new_data = '0;
    new_cnt  = AddCnt;
    case (cmd_q)
      4'd1: if (!sum[32]) begin
        new_resp = 2'd1;
        new_data = sum[31:0];
      end
      4'd2: if (req_data_in <= op1_q) begin
        new_resp = 2'd1;
        new_data = op1_q - req_data_in;
      end
      4'd5: begin
        new_resp = 2'd1;
        new_data = op1_q << req_data_in[4:0];
        new_cnt  = ShiftCnt;
      end
      4'd6: begin
        new_resp = 2'd1;
        new_data = op1_q >> req_data_in[4:0];
        new_cnt  = ShiftCnt;
      end
      default: ;
    endcase
`ifdef CALC_TAG_CHECK_EN
    if (dup_q) begin
      new_resp = 2'd2;
      new_data = '0;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    op1_d      = op1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_vld_d    = q_vld_q;
    q_resp_d   = q_resp_q;
    q_data_d   = q_data_q;
    q_tag_d    = q_tag_q;
    out_resp_d = '0;
    out_data_d = '0;
    out_tag_d  = '0;
    drop_d     = 1'b0;
`ifdef CALC_TAG_CHECK_EN
    dup_d      = dup_q;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      q_cnt_d[i] = (q_cnt_q[i] == '0) ? '0 : q_cnt_q[i] - CW'(1);
    end

    pop  = (occ_q != '0) && (q_cnt_q[rd_ptr_q] == '0);
    push = (state_q == StOp2);

    unique case (state_q)
      StIdle: begin
        if (req_cmd_in != 4'd0) begin
          if (busy) begin
            drop_d = 1'b1;
          end else begin
            cmd_d   = req_cmd_in;
            tag_d   = req_tag_in;
            op1_d   = req_data_in;
            state_d = StOp2;
`ifdef CALC_TAG_CHECK_EN
            dup_d = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
              if (q_vld_q[i] && (q_tag_q[i] == req_tag_in)) dup_d = 1'b1;
            end
`endif
          end
        end
      end
      StOp2: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (pop) begin
      out_resp_d        = q_resp_q[rd_ptr_q];
      out_data_d        = q_data_q[rd_ptr_q];
      out_tag_d         = q_tag_q[rd_ptr_q];
      q_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end

    if (push) begin
      q_vld_d[wr_ptr_q]  = 1'b1;
      q_resp_d[wr_ptr_q] = new_resp;
      q_data_d[wr_ptr_q] = new_data;
      q_tag_d[wr_ptr_q]  = tag_q;
      q_cnt_d[wr_ptr_q]  = new_cnt;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + (PW + 1)'(1);
      2'b01:   occ_d = occ_q - (PW + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      tag_q      <= '0;
      op1_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      q_vld_q    <= '0;
      out_resp_q <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      drop_q     <= 1'b0;
`ifdef CALC_TAG_CHECK_EN
      dup_q      <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        q_resp_q[i] <= '0;
        q_data_q[i] <= '0;
        q_tag_q[i]  <= '0;
        q_cnt_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
      op1_q      <= op1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      q_vld_q    <= q_vld_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      drop_q     <= drop_d;
`ifdef CALC_TAG_CHECK_EN
      dup_q      <= dup_d;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        q_resp_q[i] <= q_resp_d[i];
        q_data_q[i] <= q_data_d[i];
        q_tag_q[i]  <= q_tag_d[i];
        q_cnt_q[i]  <= q_cnt_d[i];
      end
    end
  end

  assign out_resp = out_resp_q;
  assign out_data = out_data_q;
  assign out_tag  = out_tag_q;
  assign drop_err = drop_q;

endmodule

// File: doc/calc2_port_responder.md
Name: calc2_port_responder

Overview:
- Single-port responder for the calc2 request/response protocol. It is the DUT-side end that the calc2 bench drivers talk to.
- Captures a two-cycle request (command, tag and operand1, then operand2), computes ADD/SUB/SHL/SHR, queues results and returns them in order on the out_resp/out_data/out_tag channel.
- Serves as a golden reference port model and as a building block for a multi-port calc2 top.

Parameters:
- DEPTH, 4, pending-result queue entries (power of two, 2..8).
- ADD_LAT, 2, compute latency in cycles for ADD/SUB and invalid commands (≥1).
- SHIFT_LAT, 3, compute latency in cycles for SHL/SHR (≥1).

Ports:
- c_clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state when 0.
- req_cmd_in  in  4  command; 0 = no request; 1 ADD, 2 SUB, 5 SHL, 6 SHR.
- req_data_in  in  32  operand1 in the command cycle, operand2 in the following cycle.
- req_tag_in  in  2  tag, sampled in the command cycle.
- out_resp  out  2  0 none, 1 success, 2 error.
- out_data  out  32  result; 0 when out_resp≠1.
- out_tag  out  2  tag of the returned response.
- busy  out  1  queue full; requester must not issue a command.
- drop_err  out  1  one-cycle pulse when a command is dropped.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, queue empty, FSM in IDLE.
- Reset asserted mid-operation: any captured operands and queued results are discarded; no response is emitted for them.
- FSM, state IDLE:
  - Nonzero req_cmd_in at a rising edge latches cmd, tag and op1, then goes to OP2.
  - If busy=1 at that edge: the command is not latched, drop_err pulses the next cycle, FSM stays in IDLE.
- FSM, state OP2:
  - The next rising edge latches op2 unconditionally; req_cmd_in is ignored in this cycle.
  - The result is computed and enqueued with a countdown of ADD_LAT or SHIFT_LAT, then FSM returns to IDLE.
  - Back-to-back requests are allowed: a new command may arrive in the cycle immediately after op2.
- Arithmetic:
  - ADD: 33-bit sum. Bit 32 set → resp 2, data 0.
  - SUB: op2>op1 → resp 2, data 0. Otherwise data = op1−op2.
  - SHL: op1 << op2[4:0], logical, never errors.
  - SHR: op1 >> op2[4:0], logical, never errors.
  - Any other nonzero cmd → resp 2, data 0, latency ADD_LAT.
- Queue and countdown:
  - Every entry's countdown decrements each cycle, saturating at 0.
  - When the head entry's countdown is 0, it is popped and its response registered onto out_* for exactly one cycle; otherwise out_* = 0.
  - Responses retire strictly in request order. A short-latency entry behind a long-latency head waits for the head.
  - At most one response per cycle.
- Latency: with an empty queue, the response is visible LAT+2 cycles after the command cycle. The command cycle is cycle 0.
- busy = (occupancy == DEPTH) or (occupancy == DEPTH−1 with a request in OP2).
- Simultaneous push and pop in the same edge is legal; occupancy is unchanged.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: CALC_TAG_CHECK_EN.
- Defined: a command whose tag matches any entry still pending (queued, or in OP2) is still accepted. Its result is forced to resp 2, data 0 at normal latency and order, and drop_err is not pulsed.
- Undefined: tags are not checked; duplicate tags return normal results.

Test Plan:
- ADD 0x56 + 0x103, tag 1, ADD_LAT=2 → out_resp=1, out_data=0x159, out_tag=1 in cycle 4, exactly one cycle.
- SUB 0x158 − 0x12, then back-to-back SUB 0x18 − 0x32 → first resp=1 data=0x146; next resp=2 data=0; tags preserved, order preserved.
- SHL 0x1 by 4 (SHIFT_LAT=3) followed immediately by ADD 0xFFFFFFFF + 1 → SHL resp=1 data=0x10 first; ADD then resp=2 data=0 on the very next cycle, without overtaking the SHL.
- Issue 5 requests back-to-back with no pops possible before the queue fills (DEPTH=4) → busy asserts; the 5th command is dropped and drop_err pulses once; 4 responses are returned.
- cmd 4'h3 → resp=2 data=0; reset pulled low while 2 entries are pending → outputs 0 immediately, no stale responses after release.
- With CALC_TAG_CHECK_EN: two ADD requests, both tag 2, second issued before the first retires → first resp=1, second resp=2 data=0.
